// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the BCD conversion blocks.
package bcd_pkg;

  localparam int BCD_DIGIT_W       = 4;
  localparam int BCD_MAX_DIGIT     = 9;
  localparam int DABBLE_ADJ_THRESH = 8;
  localparam int DABBLE_ADJ        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Smallest binary width able to hold 10^num_digits - 1.
  function automatic int min_bin_w(input int num_digits);
    longint max_val;
    int     w;
    max_val = 1;
    for (int i = 0; i < num_digits; i++) max_val = max_val * 10;
    max_val = max_val - 1;
    w = 0;
    while ((w < 63) && ((longint'(1) << w) <= max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust_dn.sv
// Reverse double-dabble digit correction: a digit of 8 or more after the
// right shift carried a 16 that should have been a 10, so take 3 back off.
module bcd_digit_adjust_dn
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Combinational subtract-3 when the digit reaches the threshold.
  always_comb begin
    if (digit >= BCD_DIGIT_W'(DABBLE_ADJ_THRESH)) adjusted = digit - BCD_DIGIT_W'(DABBLE_ADJ);
    else                                          adjusted = digit;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per
// cycle under a start/done handshake. Result and error flag are held between
// conversions.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] bcd_in,
  output logic                              ready,
  output logic                              done,
  output logic [BIN_W-1:0]                  bin_out,
  output logic                              err
);

  localparam int BCD_W = NUM_DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  bcd_state_t        state, state_next;
  logic [BCD_W-1:0]  d_q, d_next, d_shift, d_adj;
  logic [BIN_W-1:0]  b_q, b_next, b_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [BIN_W-1:0]  bin_q, bin_next;
  logic              err_q, err_next;
  logic              invalid;

  // Right shift of the combined {D,B} register; D's LSB moves into B's MSB.
  assign d_shift = d_q >> 1;
  assign b_shift = {d_q[0], b_q[BIN_W-1:1]};

  // Per-digit correction of the shifted digit register.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust_dn u_adj (
      .digit    (d_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (d_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag any input digit outside 0..9.
  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) invalid = 1'b1;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    d_next     = d_q;
    b_next     = b_q;
    cnt_next   = cnt_q;
    bin_next   = bin_q;
    err_next   = err_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          d_next   = bcd_in;
          b_next   = '0;
          cnt_next = '0;
          if (invalid) begin
            state_next = DONE;
            err_next   = 1'b1;
            bin_next   = '0;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        d_next   = d_adj;
        b_next   = b_shift;
        cnt_next = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_next = DONE;
          bin_next   = b_shift;
          err_next   = 1'b0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      d_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      d_q   <= d_next;
      b_q   <= b_next;
      cnt_q <= cnt_next;
      bin_q <= bin_next;
      err_q <= err_next;
    end
  end

  assign ready   = (state == IDLE);
  assign done    = (state == DONE);
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: a decimal reference model predicts
// each accepted request; a negedge monitor checks every done pulse and the
// steady-state outputs.
module tb_bcd_to_binary_seq;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    ready;
  logic                    done;
  logic [BIN_W-1:0]        bin_out;
  logic                    err;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_bad = 0;
  int               cyc = 0;
  bit               model_idle = 1'b1;
  int               busy_left = 0;
  logic [BIN_W-1:0] hold_bin = '0;
  logic             hold_err = 1'b0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal interpretation of the packed digits.
  function automatic void ref_model(input logic [4*NUM_DIGITS-1:0] v, output int val, output bit bad);
    int d;
    val = 0;
    bad = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d = int'(v[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) val = 0;
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] rand_bcd();
    logic [4*NUM_DIGITS-1:0] v;
    for (int i = 0; i < NUM_DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 4) == 0) v[$urandom_range(0, NUM_DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Reference model: decides acceptance and queues the expected response.
  initial begin
    int val;
    bit bad;
    int lat;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        model_idle = 1'b1;
        busy_left  = 0;
        hold_bin   = '0;
        hold_err   = 1'b0;
      end else if (model_idle && start) begin
        ref_model(bcd_in, val, bad);
        lat = bad ? 0 : BIN_W;
        sb.push_back('{bin: BIN_W'(val), err: bad, cyc: cyc + lat});
        busy_left  = lat + 1;
        model_idle = 1'b0;
      end else if (!model_idle) begin
        busy_left--;
        if (busy_left == 0) model_idle = 1'b1;
      end
    end
  end

  // Monitor: compares outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("ready", 32'(ready), 32'(model_idle));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("bin_out", 32'(bin_out), 32'(e.bin));
          check("err", 32'(err), 32'(e.err));
          check("latency", cyc, e.cyc);
          hold_bin = e.bin;
          hold_err = e.err;
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        check("done_missing", 32'(done), 32'd1);
        void'(sb.pop_front());
      end
      check("bin_hold", 32'(bin_out), 32'(hold_bin));
      check("err_hold", 32'(err), 32'(hold_err));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!model_idle && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!model_idle) check("idle_timeout", 32'(model_idle), 32'd1);
  endtask

  task automatic issue(input logic [4*NUM_DIGITS-1:0] v);
    wait_idle();
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  // Stimulus.
  initial begin
    logic [15:0] directed [6];
    int n;
    directed = '{16'h1234, 16'h9999, 16'h0000, 16'h0001, 16'h12A4, 16'h0042};
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    foreach (directed[i]) issue(directed[i]);

    // Start held high with the input changing every cycle.
    wait_idle();
    start = 1'b1;
    repeat (60) begin
      bcd_in = rand_bcd();
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // Abort a conversion part-way through SHIFT.
    issue(16'h5678);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(16'h0305);

    repeat (40) begin
      issue(rand_bcd());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while ((sb.size() != 0 || !model_idle) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the display-path binary-to-BCD block.
- Takes a packed NUM_DIGITS-digit BCD value, e.g. from keypad/switch entry of a decimal operand, and returns the unsigned binary value.
- Uses reverse double-dabble: one right-shift plus correction per cycle, under a start/done handshake.
- Sits between the user-input logic and the datapath operand or memory-address register.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the input.
- BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^NUM_DIGITS - 1 (4 digits -> 14 bits, max 9999).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only while ready=1.
- bcd_in  in  4*NUM_DIGITS  packed digits; [3:0]=ones, [7:4]=tens, [11:8]=hundreds, [15:12]=thousands.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when bin_out/err are valid.
- bin_out  out  BIN_W  unsigned binary result; held until next accepted start.
- err  out  1  invalid BCD digit (>9) in the last accepted input; held with bin_out.

Behaviour:
- One clock. Reset is synchronous and active-high; no asynchronous reset exists.
- Reset values: state=IDLE, ready=1, done=0, bin_out=0, err=0, iteration counter=0, shift register=0.
- rst=1 mid-conversion aborts it on that edge. No done is produced for the aborted request.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: capture bcd_in into digit register D and clear binary shift register B.
  - If any digit > 9: next state DONE, err_next=1, bin_next=0.
  - Otherwise: next state SHIFT, counter=0, err_next=0.
- IDLE, start=0: remain in IDLE.
- SHIFT, each cycle:
  - {D,B} shifts right by one; D's LSB enters B's MSB.
  - Each 4-bit digit of the shifted D that is >= 8 has 3 subtracted. Corrections are computed from the post-shift value in the same cycle, so the corrected value is what registers.
  - Counter increments. After the BIN_W-th SHIFT cycle (counter==BIN_W-1), next state is DONE.
- DONE, single cycle: done=1; bin_out=B (or 0 on error); err valid; ready=0. Next state IDLE unconditionally.
- bin_out and err are registered. Update them on the IDLE->DONE or SHIFT->DONE edge so they are stable whenever done=1, and hold them until the next DONE.
- Latency:
  - Valid input: start sampled at edge E0; done high in the cycle after edge E0+BIN_W (BIN_W+1 edges; 15 for defaults). Throughput is one conversion per BIN_W+2 cycles.
  - Invalid input: done high in the cycle after E0 (1 edge).
- start while ready=0 (SHIFT or DONE) is ignored and not queued; bcd_in changes during SHIFT have no effect.
- Arithmetic:
  - The correction never underflows: a digit >= 8 after the shift means its pre-shift value was >= 16 in the combined view, so subtracting 3 is exact.
  - No overflow is possible for valid input given the BIN_W constraint.
- Counter width: clog2(BIN_W). It must not wrap before BIN_W.

Decomposition:
- Shared package bcd_pkg:
  - localparams BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, DABBLE_ADJ_THRESH=8, DABBLE_ADJ=3;
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a function computing the minimal BIN_W for a given NUM_DIGITS.
- One sub-module: bcd_digit_adjust_dn. It is combinational over 4 bits: out = (in >= 8) ? in - 3 : in. Instantiate it NUM_DIGITS times via generate.
- The FSM, counter, and shift registers stay in the top module.

Test Plan:
- Reset then idle: rst held 2 cycles, start=0 -> ready=1, done=0, bin_out=0, err=0 every cycle.
- bcd_in=16'h1234, one-cycle start -> done pulse exactly 15 cycles after start edge; bin_out=14'd1234 (0x04D2), err=0; ready low for those 15 cycles plus the DONE cycle.
- bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F). bcd_in=16'h0000 -> bin_out=0. bcd_in=16'h0001 -> bin_out=1. Each with done after 15 cycles.
- bcd_in=16'h12A4 (tens digit 0xA) -> done in the next cycle, err=1, bin_out=0. Then 16'h0042 -> err=0, bin_out=42.
- Start held high continuously with bcd_in changing every cycle during SHIFT:
  - result equals the value captured at acceptance;
  - next acceptance occurs only in the cycle after DONE;
  - no double done.
- rst asserted at SHIFT cycle 7 of a 16'h5678 conversion -> next cycle all outputs at reset values, no done.
- A fresh 16'h0305 conversion afterwards yields 305.
